axi_lite_regbank: RTL and testbench

- Generic, parametrised AXI4-lite register bank for Open5G receiver blocks (frame sync, PSS/SSS detectors, decoders).
- Replaces per-block hand-written regmaps: a configurable number of read-only status words, read/write control words with write pulses, and a sticky interrupt status/mask pair.
- Contains its own AXI-lite slave handshake; no external interface module.

---
 rtl/axi_lite_regbank_if.sv | 34 +++
 rtl/axi_lite_regbank.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regbank_if.sv
// AXI4-lite bus bundle for the generic receiver register bank.
// The slave modport is the register bank's view; the master modport is the
// view of whatever drives the bus.
interface axi_lite_regbank_if #(
   parameter int ADDRESS_WIDTH = 11
);
   logic [ADDRESS_WIDTH-1:0] awaddr;
   logic                     awvalid;
   logic                     awready;
   logic [31:0]              wdata;
   logic [3:0]               wstrb;
   logic                     wvalid;
   logic                     wready;
   logic [1:0]               bresp;
   logic                     bvalid;
   logic                     bready;
   logic [ADDRESS_WIDTH-1:0] araddr;
   logic                     arvalid;
   logic                     arready;
   logic [31:0]              rdata;
   logic [1:0]               rresp;
   logic                     rvalid;
   logic                     rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_regbank.sv
// Generic AXI4-lite register bank for receiver blocks: fixed identification
// words, a scratch word, read-only status words, read/write control words
// with write pulses, and a sticky interrupt status/mask pair.
// Optional feature macro: REGBANK_SNAPSHOT_EN adds a snapshot control word
// at index 0x082 that freezes all status words into a shadow copy so that
// multi-word counters can be read coherently.
module axi_lite_regbank #(
   parameter logic [31:0] ID            = 32'd0,
   parameter int          ADDRESS_WIDTH = 11,
   parameter logic [31:0] MAGIC         = 32'h52424B7E,
   parameter int          NUM_RO        = 16,
   parameter int          NUM_RW        = 8,
   parameter int          NUM_IRQ       = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   axi_lite_regbank_if.slave        s_axi_if,
   input  logic [NUM_RO*32-1:0]     ro_data_i,
   output logic [NUM_RW*32-1:0]     rw_data_o,
   output logic [NUM_RW-1:0]        rw_write_o,
   input  logic [NUM_IRQ-1:0]       irq_i,
   output logic                     irq_o
);
   localparam int IDX_W = ADDRESS_WIDTH - 2;
   localparam int RO_BASE = 'h010;
   localparam int RW_BASE = 'h040;

   localparam logic [IDX_W-1:0] IDX_VERSION    = IDX_W'(12'h000);
   localparam logic [IDX_W-1:0] IDX_ID         = IDX_W'(12'h001);
   localparam logic [IDX_W-1:0] IDX_SCRATCH    = IDX_W'(12'h002);
   localparam logic [IDX_W-1:0] IDX_MAGIC      = IDX_W'(12'h003);
   localparam logic [IDX_W-1:0] IDX_INFO       = IDX_W'(12'h004);
   localparam logic [IDX_W-1:0] IDX_IRQ_STATUS = IDX_W'(12'h080);
   localparam logic [IDX_W-1:0] IDX_IRQ_MASK   = IDX_W'(12'h081);
`ifdef REGBANK_SNAPSHOT_EN
   localparam logic [IDX_W-1:0] IDX_SNAPSHOT   = IDX_W'(12'h082);
`endif

   localparam logic [31:0] VERSION = 32'h00020061;
   localparam logic [31:0] INFO    = {8'd0, 8'(NUM_IRQ), 8'(NUM_RW), 8'(NUM_RO)};

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   // Bus enable: keeps every ready low while reset is held.
   logic bus_en_q;

   // Write channel capture.
   logic                     aw_held_q, w_held_q;
   logic [ADDRESS_WIDTH-1:0] aw_addr_q;
   logic [31:0]              w_data_q;
   logic [3:0]               w_strb_q;
   logic                     bvalid_q;
   resp_e                    bresp_q;

   // Read channel.
   logic                     rvalid_q;
   logic [31:0]              rdata_q;
   resp_e                    rresp_q;

   // Register state.
   logic [31:0]              scratch_q;
   logic [31:0]              rw_q [NUM_RW];
   logic [NUM_RW-1:0]        rw_write_q;
   logic [NUM_IRQ-1:0]       irq_status_q, irq_mask_q;
   logic                     irq_q;

   // Write decode results.
   logic                     wr_exec, wr_ok, wr_scratch, wr_mask;
   logic [NUM_RW-1:0]        rw_wr;
   logic [31:0]              byte_mask, clr_word;
   logic [NUM_IRQ-1:0]       w1c_clr;
   logic [IDX_W-1:0]         wr_idx, rd_idx;

   // Read decode results.
   logic                     ar_hs;
   logic                     rd_ok;
   logic [31:0]              rd_data, irq_status_w, irq_mask_w;
   logic [NUM_RO*32-1:0]     ro_src;

`ifdef REGBANK_SNAPSHOT_EN
   logic                     wr_snap;
   logic                     snap_active_q;
   logic [NUM_RO*32-1:0]     shadow_q;
`endif

   // Address bits [1:0] select a byte within a word and carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, aw_addr_q[1:0], s_axi_if.araddr[1:0]};

   assign wr_exec   = aw_held_q && w_held_q;
   assign wr_idx    = aw_addr_q[ADDRESS_WIDTH-1:2];
   assign rd_idx    = s_axi_if.araddr[ADDRESS_WIDTH-1:2];
   assign byte_mask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
   assign ar_hs     = s_axi_if.arvalid && s_axi_if.arready;

   assign s_axi_if.awready = bus_en_q && !aw_held_q && !bvalid_q;
   assign s_axi_if.wready  = bus_en_q && !w_held_q && !bvalid_q;
   assign s_axi_if.bvalid  = bvalid_q;
   assign s_axi_if.bresp   = bresp_q;
   assign s_axi_if.arready = bus_en_q && !rvalid_q;
   assign s_axi_if.rvalid  = rvalid_q;
   assign s_axi_if.rdata   = rdata_q;
   assign s_axi_if.rresp   = rresp_q;

   assign rw_write_o = rw_write_q;
   assign irq_o      = irq_q;

   for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
      assign rw_data_o[32*g +: 32] = rw_q[g];
   end

`ifdef REGBANK_SNAPSHOT_EN
   assign ro_src = snap_active_q ? shadow_q : ro_data_i;
`else
   assign ro_src = ro_data_i;
`endif

   // Capture AW and W beats independently and run the write response.
   // NOTE: all clocked state uses non-blocking assignment so every flop sees
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         bus_en_q  <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         bus_en_q <= 1'b1;
         if (s_axi_if.awvalid && s_axi_if.awready) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= s_axi_if.awaddr;
         end else if (wr_exec) begin
            aw_held_q <= 1'b0;
         end
         if (s_axi_if.wvalid && s_axi_if.wready) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi_if.wdata;
            w_strb_q <= s_axi_if.wstrb;
         end else if (wr_exec) begin
            w_held_q <= 1'b0;
         end
         if (wr_exec) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && s_axi_if.bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Decode the held write into per-register enables.
   // NOTE: every output gets a default before any branch, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      wr_ok      = 1'b0;
      wr_scratch = 1'b0;
      wr_mask    = 1'b0;
      rw_wr      = '0;
      clr_word   = '0;
`ifdef REGBANK_SNAPSHOT_EN
      wr_snap    = 1'b0;
`endif
      if (wr_exec) begin
         case (wr_idx)
            IDX_SCRATCH:    begin wr_ok = 1'b1; wr_scratch = 1'b1; end
            IDX_IRQ_STATUS: begin wr_ok = 1'b1; clr_word = w_data_q & byte_mask; end
            IDX_IRQ_MASK:   begin wr_ok = 1'b1; wr_mask = 1'b1; end
`ifdef REGBANK_SNAPSHOT_EN
            IDX_SNAPSHOT:   begin wr_ok = 1'b1; wr_snap = 1'b1; end
`endif
            default: begin
               for (int i = 0; i < NUM_RW; i++) begin
                  if (wr_idx == IDX_W'(RW_BASE + i)) begin
                     wr_ok    = 1'b1;
                     rw_wr[i] = 1'b1;
                  end
               end
            end
         endcase
      end
      w1c_clr = clr_word[NUM_IRQ-1:0];
   end

   // Control words, scratch, interrupt state and the write strobes.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         scratch_q    <= '0;
         rw_write_q   <= '0;
         irq_status_q <= '0;
         irq_mask_q   <= '0;
         irq_q        <= 1'b0;
         for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
      end else begin
         rw_write_q <= rw_wr;
         if (wr_scratch) scratch_q <= (scratch_q & ~byte_mask) | (w_data_q & byte_mask);
         for (int i = 0; i < NUM_RW; i++) begin
            if (rw_wr[i]) rw_q[i] <= (rw_q[i] & ~byte_mask) | (w_data_q & byte_mask);
         end
         if (wr_mask) begin
            irq_mask_q <= (irq_mask_q & ~byte_mask[NUM_IRQ-1:0])
                        | (w_data_q[NUM_IRQ-1:0] & byte_mask[NUM_IRQ-1:0]);
         end
         // A new event in the same cycle as its clear keeps the bit set.
         irq_status_q <= (irq_status_q & ~w1c_clr) | irq_i;
         irq_q        <= |(irq_status_q & irq_mask_q);
      end
   end

`ifdef REGBANK_SNAPSHOT_EN
   // Snapshot enable flag.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) snap_active_q <= 1'b0;
      else if (wr_snap && w_strb_q[0]) snap_active_q <= w_data_q[0];
   end

   // Shadow copy of the status words, taken when a snapshot is requested.
   // NOTE: the shadow is storage only, never visible until a snapshot has
   // loaded it, so it is deliberately left without a reset.
   always_ff @(posedge clk_i) begin
      if (wr_snap && w_strb_q[0] && w_data_q[0]) shadow_q <= ro_data_i;
   end
`endif

   // Read mux, evaluated on the AR address during the handshake cycle.
   always_comb begin
      rd_data      = '0;
      rd_ok        = 1'b1;
      irq_status_w = '0;
      irq_mask_w   = '0;
      irq_status_w[NUM_IRQ-1:0] = irq_status_q;
      irq_mask_w[NUM_IRQ-1:0]   = irq_mask_q;
      case (rd_idx)
         IDX_VERSION:    rd_data = VERSION;
         IDX_ID:         rd_data = ID;
         IDX_SCRATCH:    rd_data = scratch_q;
         IDX_MAGIC:      rd_data = MAGIC;
         IDX_INFO:       rd_data = INFO;
         IDX_IRQ_STATUS: rd_data = irq_status_w;
         IDX_IRQ_MASK:   rd_data = irq_mask_w;
`ifdef REGBANK_SNAPSHOT_EN
         IDX_SNAPSHOT:   rd_data = {31'd0, snap_active_q};
`endif
         default: begin
            rd_ok = 1'b0;
            for (int i = 0; i < NUM_RO; i++) begin
               if (rd_idx == IDX_W'(RO_BASE + i)) begin
                  rd_ok   = 1'b1;
                  rd_data = ro_src[32*i +: 32];
               end
            end
            for (int i = 0; i < NUM_RW; i++) begin
               if (rd_idx == IDX_W'(RW_BASE + i)) begin
                  rd_ok   = 1'b1;
                  rd_data = rw_q[i];
               end
            end
         end
      endcase
   end

   // Register read data on the AR handshake and hold it until accepted.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_ok ? rd_data : 32'd0;
         rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && s_axi_if.rready) begin
         rvalid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with a response scoreboard.
// Build with REGBANK_SNAPSHOT_EN defined to exercise the snapshot word.
module tb_axi_lite_regbank;
   localparam int          AW    = 11;
   localparam int          BOUND = 16;
   localparam logic [31:0] TB_ID = 32'h1234_5678;
   localparam logic [1:0]  OKAY  = 2'b00;
   localparam logic [1:0]  SLV   = 2'b10;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic          clk_i;
   logic          reset_ni;
   logic [511:0]  ro_data_i;
   logic [255:0]  rw_data_o;
   logic [7:0]    rw_write_o;
   logic [7:0]    irq_i;
   logic          irq_o;

   int   total = 0;
   int   bad   = 0;
   exp_t rd_q[$];
   exp_t wr_q[$];

   axi_lite_regbank_if #(.ADDRESS_WIDTH(AW)) s_axi_if ();

   axi_lite_regbank #(
      .ID(TB_ID), .ADDRESS_WIDTH(AW), .MAGIC(32'h52424B7E),
      .NUM_RO(16), .NUM_RW(8), .NUM_IRQ(8)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .s_axi_if(s_axi_if),
      .ro_data_i(ro_data_i), .rw_data_o(rw_data_o), .rw_write_o(rw_write_o),
      .irq_i(irq_i), .irq_o(irq_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] wa(input int w);
      return AW'(w * 4);
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_aw_w(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic aw_done, w_done, aw_hs, w_hs;
      aw_done = 1'b0;
      w_done  = 1'b0;
      s_axi_if.awaddr  = addr;
      s_axi_if.awvalid = 1'b1;
      s_axi_if.wdata   = data;
      s_axi_if.wstrb   = strb;
      s_axi_if.wvalid  = 1'b1;
      for (int i = 0; i < BOUND && !(aw_done && w_done); i++) begin
         aw_hs = s_axi_if.awvalid && s_axi_if.awready;
         w_hs  = s_axi_if.wvalid && s_axi_if.wready;
         tick();
         if (aw_hs) begin aw_done = 1'b1; s_axi_if.awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; s_axi_if.wvalid  = 1'b0; end
      end
      s_axi_if.awvalid = 1'b0;
      s_axi_if.wvalid  = 1'b0;
      check("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
   endtask

   task automatic send_aw(input logic [AW-1:0] addr);
      logic done, hs;
      done = 1'b0;
      s_axi_if.awaddr  = addr;
      s_axi_if.awvalid = 1'b1;
      for (int i = 0; i < BOUND && !done; i++) begin
         hs = s_axi_if.awready;
         tick();
         if (hs) begin done = 1'b1; s_axi_if.awvalid = 1'b0; end
      end
      s_axi_if.awvalid = 1'b0;
      check("aw_accept", 32'(done), 32'd1);
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      logic done, hs;
      done = 1'b0;
      s_axi_if.wdata  = data;
      s_axi_if.wstrb  = strb;
      s_axi_if.wvalid = 1'b1;
      for (int i = 0; i < BOUND && !done; i++) begin
         hs = s_axi_if.wready;
         tick();
         if (hs) begin done = 1'b1; s_axi_if.wvalid = 1'b0; end
      end
      s_axi_if.wvalid = 1'b0;
      check("w_accept", 32'(done), 32'd1);
   endtask

   task automatic get_b();
      exp_t e;
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < BOUND && !seen; i++) begin
         if (s_axi_if.bvalid) seen = 1'b1;
         else tick();
      end
      check("bvalid_seen", 32'(seen), 32'd1);
      if (wr_q.size() > 0) begin
         e = wr_q.pop_front();
         check({e.tag, "_bresp"}, 32'(s_axi_if.bresp), 32'(e.resp));
      end
      s_axi_if.bready = 1'b1;
      tick();
      s_axi_if.bready = 1'b0;
      check("bvalid_drop", 32'(s_axi_if.bvalid), 32'd0);
   endtask

   task automatic send_ar(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input string tag);
      logic done, hs;
      exp_t e;
      e.tag = tag; e.data = data; e.resp = resp;
      rd_q.push_back(e);
      done = 1'b0;
      s_axi_if.araddr  = addr;
      s_axi_if.arvalid = 1'b1;
      for (int i = 0; i < BOUND && !done; i++) begin
         hs = s_axi_if.arready;
         tick();
         if (hs) begin done = 1'b1; s_axi_if.arvalid = 1'b0; end
      end
      s_axi_if.arvalid = 1'b0;
      check("ar_accept", 32'(done), 32'd1);
   endtask

   task automatic get_r();
      exp_t e;
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < BOUND && !seen; i++) begin
         if (s_axi_if.rvalid) seen = 1'b1;
         else tick();
      end
      check("rvalid_seen", 32'(seen), 32'd1);
      if (rd_q.size() > 0) begin
         e = rd_q.pop_front();
         check({e.tag, "_rdata"}, s_axi_if.rdata, e.data);
         check({e.tag, "_rresp"}, 32'(s_axi_if.rresp), 32'(e.resp));
      end
      s_axi_if.rready = 1'b1;
      tick();
      s_axi_if.rready = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input string tag);
      exp_t e;
      e.tag = tag; e.data = data; e.resp = resp;
      wr_q.push_back(e);
      send_aw_w(addr, data, strb);
      get_b();
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input string tag);
      send_ar(addr, data, resp, tag);
      get_r();
   endtask

   task automatic push_wr(input logic [1:0] resp, input string tag);
      exp_t e;
      e.tag = tag; e.data = '0; e.resp = resp;
      wr_q.push_back(e);
   endtask

   initial begin
      reset_ni         = 1'b0;
      ro_data_i        = '0;
      irq_i            = '0;
      s_axi_if.awaddr  = '0;
      s_axi_if.awvalid = 1'b0;
      s_axi_if.wdata   = '0;
      s_axi_if.wstrb   = '0;
      s_axi_if.wvalid  = 1'b0;
      s_axi_if.bready  = 1'b0;
      s_axi_if.araddr  = '0;
      s_axi_if.arvalid = 1'b0;
      s_axi_if.rready  = 1'b0;
      tick();
      tick();

      // Outputs while reset is held.
      check("rst_awready", 32'(s_axi_if.awready), 32'd0);
      check("rst_wready",  32'(s_axi_if.wready),  32'd0);
      check("rst_arready", 32'(s_axi_if.arready), 32'd0);
      check("rst_valids",  {30'd0, s_axi_if.bvalid, s_axi_if.rvalid}, 32'd0);
      check("rst_rdata",   s_axi_if.rdata, 32'd0);
      check("rst_rw_any",  32'(|rw_data_o), 32'd0);
      check("rst_irq_o",   32'(irq_o), 32'd0);
      reset_ni = 1'b1;
      tick();

      // Identification words.
      do_read(wa('h000), 32'h00020061, OKAY, "version");
      do_read(wa('h001), TB_ID,        OKAY, "id");
      do_read(wa('h003), 32'h52424B7E, OKAY, "magic");
      do_read(wa('h004), 32'h00080810, OKAY, "info");

      // W three cycles ahead of AW, partial strobe, response held with bready low.
      push_wr(OKAY, "rw1_write");
      send_w(32'hDEADBEEF, 4'b0011);
      check("w_held_wready", 32'(s_axi_if.wready), 32'd0);
      tick();
      tick();
      send_aw(wa('h041));
      check("rw1_pre_pulse", 32'(rw_write_o), 32'd0);
      check("rw1_pre_bvalid", 32'(s_axi_if.bvalid), 32'd0);
      tick();
      check("rw1_pulse", 32'(rw_write_o), 32'h02);
      check("rw1_data", rw_data_o[63:32], 32'h0000BEEF);
      for (int i = 0; i < 4; i++) begin
         check("rw1_bvalid_hold", 32'(s_axi_if.bvalid), 32'd1);
         if (i == 0) begin
            tick();
            check("rw1_pulse_end", 32'(rw_write_o), 32'd0);
         end else begin
            tick();
         end
      end
      get_b();
      do_read(wa('h041), 32'h0000BEEF, OKAY, "rw1_readback");

      // Zero strobe: pulse still fires, data unchanged.
      push_wr(OKAY, "rw2_nostrb");
      send_aw_w(wa('h042), 32'hFFFFFFFF, 4'b0000);
      tick();
      check("rw2_pulse", 32'(rw_write_o), 32'h04);
      check("rw2_data", rw_data_o[95:64], 32'd0);
      get_b();

      // Scratch with byte strobes.
      do_write(wa('h002), 32'h12345678, 4'hF, OKAY, "scr_full");
      do_write(wa('h002), 32'hAABBCCDD, 4'b0100, OKAY, "scr_byte2");
      do_read(wa('h002), 32'h12BB5678, OKAY, "scr_read");

      // Read-only and unmapped accesses.
      ro_data_i[31:0] = 32'hCAFE0000;
      do_write(wa('h010), 32'hFFFFFFFF, 4'hF, SLV, "ro_write");
      do_read(wa('h010), 32'hCAFE0000, OKAY, "ro_read");
      do_write(wa('h000), 32'h0, 4'hF, SLV, "ver_write");
      do_read(wa('h000), 32'h00020061, OKAY, "ver_after");
      do_write(wa('h048), 32'h1, 4'hF, SLV, "unm_write");
      check("rw_after_err", rw_data_o[63:32], 32'h0000BEEF);
      check("rw0_after_err", rw_data_o[31:0], 32'd0);
      do_read(wa('h0FF), 32'd0, SLV, "unm_0ff");
      do_read(wa('h020), 32'd0, SLV, "unm_ro_end");
      do_read(wa('h048), 32'd0, SLV, "unm_rw_end");

      // Read sampled in the write-execute cycle returns the old value.
      do_write(wa('h002), 32'h11111111, 4'hF, OKAY, "scr_old");
      push_wr(OKAY, "scr_new");
      send_aw_w(wa('h002), 32'h22222222, 4'hF);
      send_ar(wa('h002), 32'h11111111, OKAY, "rd_prewrite");
      get_r();
      get_b();
      do_read(wa('h002), 32'h22222222, OKAY, "rd_postwrite");

      // Interrupts.
      do_write(wa('h081), 32'h00000004, 4'hF, OKAY, "mask_wr");
      do_read(wa('h081), 32'h00000004, OKAY, "mask_rd");
      irq_i = 8'h20;
      tick();
      irq_i = 8'h00;
      tick();
      check("irq_unmasked", 32'(irq_o), 32'd0);
      do_read(wa('h080), 32'h00000020, OKAY, "stat_unmasked");
      do_write(wa('h080), 32'h00000020, 4'hF, OKAY, "w1c_unmasked");
      irq_i = 8'h04;
      tick();
      irq_i = 8'h00;
      check("irq_lat0", 32'(irq_o), 32'd0);
      tick();
      check("irq_lat1", 32'(irq_o), 32'd1);
      do_read(wa('h080), 32'h00000004, OKAY, "stat_set");
      do_write(wa('h080), 32'h00000004, 4'b1110, OKAY, "w1c_nostrb");
      do_read(wa('h080), 32'h00000004, OKAY, "stat_nostrb");
      push_wr(OKAY, "w1c_race");
      send_aw_w(wa('h080), 32'h00000004, 4'hF);
      irq_i = 8'h04;
      tick();
      irq_i = 8'h00;
      get_b();
      do_read(wa('h080), 32'h00000004, OKAY, "stat_race");
      check("irq_race", 32'(irq_o), 32'd1);
      push_wr(OKAY, "w1c_clear");
      send_aw_w(wa('h080), 32'h00000004, 4'hF);
      tick();
      check("irq_clr_lat", 32'(irq_o), 32'd1);
      tick();
      check("irq_cleared", 32'(irq_o), 32'd0);
      get_b();
      do_read(wa('h080), 32'd0, OKAY, "stat_clear");

      // Reset in the middle of a write: AW captured, W still pending.
      send_aw(wa('h040));
      #2;
      reset_ni = 1'b0;
      #1;
      check("mid_awready", 32'(s_axi_if.awready), 32'd0);
      check("mid_wready",  32'(s_axi_if.wready),  32'd0);
      check("mid_arready", 32'(s_axi_if.arready), 32'd0);
      check("mid_bvalid",  32'(s_axi_if.bvalid),  32'd0);
      check("mid_rw_any",  32'(|rw_data_o), 32'd0);
      check("mid_strobes", 32'(rw_write_o), 32'd0);
      tick();
      tick();
      reset_ni = 1'b1;
      tick();
      do_write(wa('h040), 32'hA5A5A5A5, 4'hF, OKAY, "post_rst_wr");
      check("post_rst_rw0", rw_data_o[31:0], 32'hA5A5A5A5);
      check("post_rst_rw1", rw_data_o[63:32], 32'd0);
      do_read(wa('h040), 32'hA5A5A5A5, OKAY, "post_rst_rd");
      do_read(wa('h002), 32'd0, OKAY, "post_rst_scr");

`ifdef REGBANK_SNAPSHOT_EN
      ro_data_i[31:0] = 32'd5;
      do_write(wa('h082), 32'd1, 4'hF, OKAY, "snap_on");
      ro_data_i[31:0] = 32'd9;
      do_read(wa('h010), 32'd5, OKAY, "snap_frozen");
      do_read(wa('h082), 32'd1, OKAY, "snap_flag");
      do_write(wa('h082), 32'd0, 4'hF, OKAY, "snap_off");
      do_read(wa('h010), 32'd9, OKAY, "snap_live");
      do_read(wa('h082), 32'd0, OKAY, "snap_flag_off");
`else
      ro_data_i[31:0] = 32'd5;
      do_write(wa('h082), 32'd1, 4'hF, SLV, "snap_unmapped_wr");
      ro_data_i[31:0] = 32'd9;
      do_read(wa('h010), 32'd9, OKAY, "ro_live");
      do_read(wa('h082), 32'd0, SLV, "snap_unmapped_rd");
`endif

      check("sb_rd_empty", 32'(rd_q.size()), 32'd0);
      check("sb_wr_empty", 32'(wr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
